// File: rtl/ls163_ctrl_front.sv
`default_nettype none
// ============================================================================
// Module   : ls163_ctrl_front
// Purpose  : Board front end for a 74LS163-style counter. Synchronises and
//            debounces the push-buttons, turns presses into one-cycle
//            active-low clear/load strobes, latches switch data for parallel
//            load, and produces enp from a prescaler (run) or from single-step
//            presses (step).
// Revision : 1.0 - initial release
// ============================================================================
module ls163_ctrl_front #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int PRESCALE        = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_clear,
  input  logic       btn_load,
  input  logic       btn_step,
  input  logic       sw_run,
  input  logic [3:0] sw_data,
  output logic       clear_n,
  output logic       load_n,
  output logic       ent,
  output logic       enp,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  // Bit map of the synchroniser vector: [2:0] buttons {step,load,clear},
  // [3] run switch, [7:4] data switches {d,c,b,a}.
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic [2:0] btn_s;
  logic       run_s;
  logic [3:0] data_s;
  logic [2:0] press_w;

  // Two-stage synchroniser input selection for every raw pin.
  always_comb begin
    sync1_d = {sw_data, sw_run, btn_step, btn_load, btn_clear};
    sync2_d = sync1_q;
  end

  // Synchroniser flops; nothing downstream looks at the raw pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_s  = sync2_q[2:0];
  assign run_s  = sync2_q[3];
  assign data_s = sync2_q[7:4];

  // One debouncer per button. A press event is the 0->1 edge of the
  // debounced level, seen one cycle after the level flips.
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          prev_q, prev_d;

    // Count while synced and debounced levels disagree; flip at the limit.
    always_comb begin
      cnt_d  = '0;
      deb_d  = deb_q;
      prev_d = deb_q;
      if (btn_s[i] != deb_q) begin
        if (cnt_q == DB_LAST) begin
          deb_d = btn_s[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        deb_q  <= 1'b0;
        prev_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        deb_q  <= deb_d;
        prev_q <= prev_d;
      end
    end

    assign press_w[i] = deb_q & ~prev_q;
  end

  logic          clear_n_q, clear_n_d;
  logic          load_n_q, load_n_d;
  logic          ent_q, ent_d;
  logic          enp_q, enp_d;
  logic [3:0]    data_q, data_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          clr_ev, ld_ev, st_ev;

  // Strobe generation with clear > load > step/run priority, plus prescaler.
  always_comb begin
    clr_ev    = press_w[0];
    ld_ev     = press_w[1] & ~clr_ev;
    st_ev     = press_w[2];
    clear_n_d = ~clr_ev;
    load_n_d  = ~ld_ev;
    ent_d     = 1'b1;
    data_d    = data_q;
    pre_d     = '0;
    enp_d     = 1'b0;
    if (ld_ev) begin
      data_d = data_s;
    end
    if (run_s) begin
      // A suppressed tick is lost but the count still wraps normally.
      if (!clr_ev && pre_q != PRE_LAST) begin
        pre_d = pre_q + 1'b1;
      end
      enp_d = (pre_q == PRE_LAST) & ~clr_ev & ~ld_ev;
    end else begin
      enp_d = st_ev & ~clr_ev & ~ld_ev;
    end
  end

  // Output registers; reset holds the counter in clear with counting off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_n_q <= 1'b0;
      load_n_q  <= 1'b1;
      ent_q     <= 1'b0;
      enp_q     <= 1'b0;
      data_q    <= '0;
      pre_q     <= '0;
    end else begin
      clear_n_q <= clear_n_d;
      load_n_q  <= load_n_d;
      ent_q     <= ent_d;
      enp_q     <= enp_d;
      data_q    <= data_d;
      pre_q     <= pre_d;
    end
  end

  assign clear_n = clear_n_q;
  assign load_n  = load_n_q;
  assign ent     = ent_q;
  assign enp     = enp_q;
  assign a       = data_q[0];
  assign b       = data_q[1];
  assign c       = data_q[2];
  assign d       = data_q[3];

endmodule
`default_nettype wire

// File: tb/tb_ls163_ctrl_front.sv
`default_nettype none
// ============================================================================
// Module   : tb_ls163_ctrl_front
// Purpose  : Directed self-checking bench for ls163_ctrl_front
//            (DEBOUNCE_CYCLES=4, PRESCALE=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ls163_ctrl_front;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_clear, btn_load, btn_step, sw_run;
  logic [3:0] sw_data;
  logic       clear_n, load_n, ent, enp, a, b, c, d;

  int checks = 0;
  int errors = 0;
  int n_clr = 0, n_ld = 0, n_enp = 0;
  int base;

  always #5 clk = ~clk;

  ls163_ctrl_front #(.DEBOUNCE_CYCLES(4), .PRESCALE(5)) dut (
    .clk(clk), .reset(reset),
    .btn_clear(btn_clear), .btn_load(btn_load), .btn_step(btn_step),
    .sw_run(sw_run), .sw_data(sw_data),
    .clear_n(clear_n), .load_n(load_n), .ent(ent), .enp(enp),
    .a(a), .b(b), .c(c), .d(d)
  );

  // Pulse counters sampled mid-cycle, outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (clear_n === 1'b0) n_clr++;
      if (load_n === 1'b0)  n_ld++;
      if (enp === 1'b1)     n_enp++;
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; btn_clear = 1'b0; btn_load = 1'b0; btn_step = 1'b0;
    sw_run = 1'b0; sw_data = 4'b0000;
    #2 reset = 1'b1;
    #1;
    // 1. reset state
    check("rst_clear_n", {7'd0, clear_n}, 8'd0);
    check("rst_load_n",  {7'd0, load_n},  8'd1);
    check("rst_ent",     {7'd0, ent},     8'd0);
    check("rst_enp",     {7'd0, enp},     8'd0);
    check("rst_abcd",    {4'd0, d, c, b, a}, 8'd0);
    cyc(3);
    check("rst_hold_clear_n", {7'd0, clear_n}, 8'd0);
    reset = 1'b0;
    cyc(1);
    check("rel_clear_n", {7'd0, clear_n}, 8'd1);
    check("rel_ent",     {7'd0, ent},     8'd1);
    cyc(3);

    // 2. parallel load
    base = n_ld;
    sw_data = 4'b1010; btn_load = 1'b1;
    cyc(6);
    check("load_early", {7'd0, load_n}, 8'd1);
    check("abcd_preload", {4'd0, d, c, b, a}, 8'd0);
    cyc(1);
    check("load_strobe", {7'd0, load_n}, 8'd0);
    check("load_abcd",   {4'd0, d, c, b, a}, 8'ha);
    check("load_enp",    {7'd0, enp}, 8'd0);
    cyc(1);
    check("load_end",    {7'd0, load_n}, 8'd1);
    cyc(2);
    btn_load = 1'b0;
    cyc(15);
    check("load_abcd_held", {4'd0, d, c, b, a}, 8'ha);
    check("load_pulses", 8'(n_ld - base), 8'd1);

    // 3. step: short bursts filtered, clean press gives one enp
    base = n_enp;
    for (int k = 0; k < 4; k++) begin
      btn_step = 1'b1; cyc(2);
      btn_step = 1'b0; cyc(2);
    end
    cyc(10);
    check("glitch_enp", 8'(n_enp - base), 8'd0);
    btn_step = 1'b1;
    cyc(6);
    check("step_early", {7'd0, enp}, 8'd0);
    cyc(1);
    check("step_pulse", {7'd0, enp}, 8'd1);
    cyc(1);
    check("step_end",   {7'd0, enp}, 8'd0);
    cyc(2);
    btn_step = 1'b0;
    cyc(15);
    check("step_pulses", 8'(n_enp - base), 8'd1);

    // 4. run mode: first tick 5 cycles after the synced switch, then every 5
    base = n_enp;
    sw_run = 1'b1;
    cyc(6);
    check("run_early", {7'd0, enp}, 8'd0);
    cyc(1);
    check("run_tick1", {7'd0, enp}, 8'd1);
    cyc(5);
    check("run_tick2", {7'd0, enp}, 8'd1);
    cyc(18);
    sw_run = 1'b0;
    cyc(10);
    check("run_pulses", 8'(n_enp - base), 8'd6);
    base = n_enp;
    cyc(12);
    check("run_stopped", 8'(n_enp - base), 8'd0);

    // 5. simultaneous clear and load: clear wins, data untouched
    base = n_ld;
    sw_data = 4'b0101; btn_clear = 1'b1; btn_load = 1'b1;
    cyc(7);
    check("cl_clear_n", {7'd0, clear_n}, 8'd0);
    check("cl_load_n",  {7'd0, load_n},  8'd1);
    check("cl_enp",     {7'd0, enp},     8'd0);
    check("cl_abcd",    {4'd0, d, c, b, a}, 8'ha);
    cyc(1);
    check("cl_clear_end", {7'd0, clear_n}, 8'd1);
    cyc(2);
    btn_clear = 1'b0; btn_load = 1'b0;
    cyc(15);
    check("cl_load_pulses", 8'(n_ld - base), 8'd0);
    check("cl_abcd_held", {4'd0, d, c, b, a}, 8'ha);

    // 6. reset in the middle of a clear debounce
    btn_clear = 1'b1;
    cyc(4);
    reset = 1'b1;
    #1;
    check("mid_rst_clear_n", {7'd0, clear_n}, 8'd0);
    check("mid_rst_ent",     {7'd0, ent},     8'd0);
    check("mid_rst_abcd",    {4'd0, d, c, b, a}, 8'd0);
    cyc(1);
    btn_clear = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("mid_rel_clear_n", {7'd0, clear_n}, 8'd1);
    base = n_clr;
    cyc(15);
    check("no_late_clear", 8'(n_clr - base), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
